// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode stage between IF and EX: control-ROM id decode,
// load-use bubbles, post-flush squash, sticky halt and EX backpressure.
module decode_stage_pipe #(
  parameter int DATA_W       = 8,
  parameter int PC_W         = 8,
  parameter int INSTR_W      = 8,
  parameter int REG_AW       = 2,
  parameter int CTRL_W       = 12,
  parameter int FLUSH_CYCLES = 1,
  parameter int LOAD_DM      = 1
) (
  input  logic                sig_clk,
  input  logic                sig_rst_n,
  output logic                sig_hlt,
  output logic                sig_stall,
  input  logic                IF_valid,
  input  logic [PC_W-1:0]     IF_addr_pgm,
  input  logic [INSTR_W-1:0]  DM_data_pgm,
  input  logic                EX_stall,
  output logic [REG_AW-1:0]   RF_addr_read_a,
  output logic [REG_AW-1:0]   RF_addr_read_b,
  input  logic [DATA_W-1:0]   RF_data_read_a,
  input  logic [DATA_W-1:0]   RF_data_read_b,
  output logic [4:0]          ROM_addr,
  input  logic [CTRL_W-1:0]   ROM_data,
  output logic                EX_valid,
  output logic [PC_W-1:0]     EX_addr_pgm,
  output logic [CTRL_W-6:0]   EX_sig_ctrl_EX,
  output logic [1:0]          EX_sig_ctrl_DM,
  output logic                EX_sig_ctrl_RF,
  output logic [DATA_W-1:0]   FW_data_a,
  output logic [DATA_W-1:0]   FW_data_b,
  output logic [REG_AW-1:0]   EX_FW_addr_a,
  output logic [REG_AW-1:0]   FW_addr_b
);

  logic [1:0] squash_cnt;
  logic       instr_type;
  logic       hazard;
  logic       squashing;
  logic       issue;

  assign RF_addr_read_a = DM_data_pgm[REG_AW-1:0];
  assign RF_addr_read_b = DM_data_pgm[2*REG_AW-1:REG_AW];

  // Only the 2'b11 opcode prefix selects the short-id encoding.
  assign instr_type = ~&DM_data_pgm[INSTR_W-1:INSTR_W-2];

  always_comb begin
    ROM_addr = '0;
    if (instr_type) ROM_addr = {1'b1, DM_data_pgm[INSTR_W-1:INSTR_W-4]};
    else            ROM_addr = {1'b0, DM_data_pgm[INSTR_W-3:INSTR_W-6]};
  end

  assign hazard = EX_valid & (EX_sig_ctrl_DM == 2'(LOAD_DM)) & EX_sig_ctrl_RF &
                  ((EX_FW_addr_a == RF_addr_read_a) | (EX_FW_addr_a == RF_addr_read_b));

  assign squashing = ~sig_hlt & (squash_cnt != 2'd0) & IF_valid;
  assign issue     = ~sig_hlt & (squash_cnt == 2'd0) & IF_valid & ~hazard;

  assign sig_stall = IF_valid & (EX_stall | sig_hlt | (hazard & (squash_cnt == 2'd0)));

  always_ff @(posedge sig_clk) begin
    if (!sig_rst_n) begin
      EX_valid       <= 1'b0;
      EX_addr_pgm    <= '0;
      EX_sig_ctrl_EX <= '0;
      EX_sig_ctrl_DM <= '0;
      EX_sig_ctrl_RF <= 1'b0;
      FW_data_a      <= '0;
      FW_data_b      <= '0;
      EX_FW_addr_a   <= '0;
      FW_addr_b      <= '0;
      sig_hlt        <= 1'b0;
      squash_cnt     <= 2'd0;
    end else if (!EX_stall) begin
      if (issue) begin
        EX_valid       <= 1'b1;
        EX_sig_ctrl_EX <= ROM_data[CTRL_W-6:0];
        EX_sig_ctrl_RF <= ROM_data[CTRL_W-5];
        EX_sig_ctrl_DM <= ROM_data[CTRL_W-3:CTRL_W-4];
        EX_addr_pgm    <= IF_addr_pgm;
        FW_data_a      <= RF_data_read_a;
        FW_data_b      <= RF_data_read_b;
        EX_FW_addr_a   <= RF_addr_read_a;
        FW_addr_b      <= RF_addr_read_b;
        if (ROM_data[CTRL_W-1]) sig_hlt <= 1'b1;
      end else begin
        // Bubble: control cleared so a stale load cannot re-trigger the hazard.
        EX_valid       <= 1'b0;
        EX_sig_ctrl_EX <= '0;
        EX_sig_ctrl_RF <= 1'b0;
        EX_sig_ctrl_DM <= '0;
      end
      if (squashing)
        squash_cnt <= squash_cnt - 2'd1;
      else if (issue && ROM_data[CTRL_W-2])
        squash_cnt <= 2'(FLUSH_CYCLES);
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed and randomized checks of decode_stage_pipe
// against a rule-level reference model.
module tb_decode_stage_pipe;

  localparam int FLUSH = 2;

  logic        sig_clk;
  logic        sig_rst_n;
  logic        sig_hlt;
  logic        sig_stall;
  logic        IF_valid;
  logic [7:0]  IF_addr_pgm;
  logic [7:0]  DM_data_pgm;
  logic        EX_stall;
  logic [1:0]  RF_addr_read_a;
  logic [1:0]  RF_addr_read_b;
  logic [7:0]  RF_data_read_a;
  logic [7:0]  RF_data_read_b;
  logic [4:0]  ROM_addr;
  logic [11:0] ROM_data;
  logic        EX_valid;
  logic [7:0]  EX_addr_pgm;
  logic [6:0]  EX_sig_ctrl_EX;
  logic [1:0]  EX_sig_ctrl_DM;
  logic        EX_sig_ctrl_RF;
  logic [7:0]  FW_data_a;
  logic [7:0]  FW_data_b;
  logic [1:0]  EX_FW_addr_a;
  logic [1:0]  FW_addr_b;

  logic [11:0] rom [32];
  logic [7:0]  rf  [4];

  assign ROM_data       = rom[ROM_addr];
  assign RF_data_read_a = rf[RF_addr_read_a];
  assign RF_data_read_b = rf[RF_addr_read_b];

  decode_stage_pipe #(
    .DATA_W(8), .PC_W(8), .INSTR_W(8), .REG_AW(2), .CTRL_W(12),
    .FLUSH_CYCLES(FLUSH), .LOAD_DM(1)
  ) dut (
    .sig_clk(sig_clk), .sig_rst_n(sig_rst_n), .sig_hlt(sig_hlt), .sig_stall(sig_stall),
    .IF_valid(IF_valid), .IF_addr_pgm(IF_addr_pgm), .DM_data_pgm(DM_data_pgm),
    .EX_stall(EX_stall), .RF_addr_read_a(RF_addr_read_a), .RF_addr_read_b(RF_addr_read_b),
    .RF_data_read_a(RF_data_read_a), .RF_data_read_b(RF_data_read_b),
    .ROM_addr(ROM_addr), .ROM_data(ROM_data), .EX_valid(EX_valid),
    .EX_addr_pgm(EX_addr_pgm), .EX_sig_ctrl_EX(EX_sig_ctrl_EX),
    .EX_sig_ctrl_DM(EX_sig_ctrl_DM), .EX_sig_ctrl_RF(EX_sig_ctrl_RF),
    .FW_data_a(FW_data_a), .FW_data_b(FW_data_b),
    .EX_FW_addr_a(EX_FW_addr_a), .FW_addr_b(FW_addr_b)
  );

  initial begin
    sig_clk = 1'b0;
    forever #5 sig_clk = ~sig_clk;
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state: what EX should hold, as plain integers.
  int m_valid, m_ex, m_dm, m_rf, m_da, m_db, m_aa, m_ab, m_pc, m_hlt, m_squash;
  int last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int decode_id(input int instr);
    if ((instr >> 6) == 3) return (instr >> 2) & 15;
    return 16 + (instr >> 4);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ex = 0; m_dm = 0; m_rf = 0; m_da = 0; m_db = 0;
    m_aa = 0; m_ab = 0; m_pc = 0; m_hlt = 0; m_squash = 0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_ex = 0; m_dm = 0; m_rf = 0;
  endtask

  // One clock: drive inputs, check combinational outputs, then registered outputs.
  task automatic step(input bit rst, input bit ifv, input bit exs,
                      input logic [7:0] instr, input logic [7:0] pc);
    int id, ra, rb, word, load_use, exp_stall;
    sig_rst_n = ~rst; IF_valid = ifv; EX_stall = exs;
    DM_data_pgm = instr; IF_addr_pgm = pc;
    id = decode_id(int'(instr));
    ra = instr % 4;
    rb = (instr / 4) % 4;
    word = int'(rom[id]);
    load_use = (m_valid && m_dm == 1 && m_rf && (m_aa == ra || m_aa == rb)) ? 1 : 0;
    exp_stall = (ifv && (exs || m_hlt != 0 || (load_use != 0 && m_squash == 0))) ? 1 : 0;
    #1;
    last_stall = int'(sig_stall);
    if (!rst) begin
      chk("rom_addr", 32'(ROM_addr), 32'(id));
      chk("rf_addr_a", 32'(RF_addr_read_a), 32'(ra));
      chk("rf_addr_b", 32'(RF_addr_read_b), 32'(rb));
      chk("sig_stall", 32'(sig_stall), 32'(exp_stall));
    end
    if (rst) model_reset();
    else if (exs) begin end
    else if (m_hlt != 0) model_bubble();
    else if (m_squash > 0 && ifv) begin model_bubble(); m_squash--; end
    else if (!ifv) model_bubble();
    else if (load_use != 0) model_bubble();
    else begin
      m_valid = 1;
      m_ex = word % 128;
      m_rf = (word / 128) % 2;
      m_dm = (word / 256) % 4;
      m_da = int'(rf[ra]); m_db = int'(rf[rb]);
      m_aa = ra; m_ab = rb; m_pc = int'(pc);
      if ((word / 2048) % 2 == 1) m_hlt = 1;
      if ((word / 1024) % 2 == 1) m_squash = FLUSH;
    end
    @(posedge sig_clk);
    #1;
    chk("ex_valid", 32'(EX_valid), 32'(m_valid));
    chk("ctrl_ex", 32'(EX_sig_ctrl_EX), 32'(m_ex));
    chk("ctrl_dm", 32'(EX_sig_ctrl_DM), 32'(m_dm));
    chk("ctrl_rf", 32'(EX_sig_ctrl_RF), 32'(m_rf));
    chk("fw_data_a", 32'(FW_data_a), 32'(m_da));
    chk("fw_data_b", 32'(FW_data_b), 32'(m_db));
    chk("fw_addr_a", 32'(EX_FW_addr_a), 32'(m_aa));
    chk("fw_addr_b", 32'(FW_addr_b), 32'(m_ab));
    chk("ex_addr_pgm", 32'(EX_addr_pgm), 32'(m_pc));
    chk("sig_hlt", 32'(sig_hlt), 32'(m_hlt));
    @(negedge sig_clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 12'h000;
    rf[0] = 8'hA1; rf[1] = 8'h3C; rf[2] = 8'h5E; rf[3] = 8'hC7;
    rom[5'h10] = 12'h080;
    rom[5'h11] = 12'h18C;
    rom[5'h12] = 12'h080;
    rom[5'h13] = 12'h490;
    rom[5'h14] = 12'h800;
    rom[5'h15] = 12'h10C;
    model_reset();
    sig_rst_n = 1'b0; IF_valid = 1'b1; EX_stall = 1'b0;
    DM_data_pgm = 8'h05; IF_addr_pgm = 8'h00;
    @(negedge sig_clk);

    // Reset held two cycles with IF_valid high
    step(1, 1, 0, 8'h05, 8'h00);
    step(1, 1, 0, 8'h05, 8'h01);
    chk("reset_ex_valid", 32'(EX_valid), 32'd0);
    chk("reset_hlt", 32'(sig_hlt), 32'd0);

    // Basic issue: id 0x10, RF write, operand a from reg 1
    step(0, 1, 0, 8'h05, 8'h10);
    chk("issue_valid", 32'(EX_valid), 32'd1);
    chk("issue_rf", 32'(EX_sig_ctrl_RF), 32'd1);
    chk("issue_data_a", 32'(FW_data_a), 32'h3C);
    chk("issue_addr_a", 32'(EX_FW_addr_a), 32'd1);

    // Load-use: load writing reg 2, then consumer of reg 2
    step(0, 1, 0, 8'h12, 8'h11);
    step(0, 1, 0, 8'h22, 8'h12);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(EX_valid), 32'd0);
    step(0, 1, 0, 8'h22, 8'h12);
    chk("lu_stall_clear", 32'(last_stall), 32'd0);
    chk("lu_issue", 32'(EX_valid), 32'd1);

    // Load without RF write never creates a hazard
    step(0, 1, 0, 8'h52, 8'h13);
    step(0, 1, 0, 8'h22, 8'h14);
    chk("nowr_no_stall", 32'(last_stall), 32'd0);

    // Squash: two following valid instructions discarded, third issues
    step(0, 1, 0, 8'h30, 8'h20);
    step(0, 0, 0, 8'h05, 8'h21);
    step(0, 1, 0, 8'h05, 8'h21);
    chk("sq1_valid", 32'(EX_valid), 32'd0);
    step(0, 1, 0, 8'h05, 8'h22);
    chk("sq2_stall", 32'(last_stall), 32'd0);
    step(0, 1, 0, 8'h05, 8'h23);
    chk("sq_third_issue", 32'(EX_valid), 32'd1);

    // Backpressure during a load-use hazard
    step(0, 1, 0, 8'h12, 8'h30);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h22, 8'h31);
    chk("bp_held_valid", 32'(EX_valid), 32'd1);
    step(0, 1, 0, 8'h22, 8'h31);
    chk("bp_bubble", 32'(EX_valid), 32'd0);
    step(0, 1, 0, 8'h22, 8'h31);
    chk("bp_issue", 32'(EX_valid), 32'd1);

    // Halt: sticky, stalls IF, no further issue, EX_stall still honoured
    step(0, 1, 0, 8'h40, 8'h40);
    chk("halt_set", 32'(sig_hlt), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, i == 1, 8'h05, 8'h41);
    chk("halt_stall", 32'(last_stall), 32'd1);
    chk("halt_no_issue", 32'(EX_valid), 32'd0);
    step(1, 1, 0, 8'h05, 8'h42);
    chk("halt_cleared", 32'(sig_hlt), 32'd0);

    // Reset mid-squash aborts it
    step(0, 1, 0, 8'h30, 8'h50);
    step(1, 1, 0, 8'h05, 8'h51);
    step(0, 1, 0, 8'h05, 8'h51);
    chk("rst_abort_squash", 32'(EX_valid), 32'd1);

    // Randomized phase
    for (int i = 0; i < 32; i++) begin
      logic [11:0] w;
      w = 12'($urandom);
      if ($urandom_range(0, 1) == 0) w[9:8] = 2'd1;
      w[11] = ($urandom_range(0, 20) == 0);
      w[10] = ($urandom_range(0, 5) == 0);
      rom[i] = w;
    end
    for (int i = 0; i < 4; i++) rf[i] = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      bit rst;
      rst = ($urandom_range(0, 60) == 0) || (m_hlt != 0 && $urandom_range(0, 4) == 0);
      step(rst, $urandom_range(0, 4) != 0, $urandom_range(0, 6) == 0,
           8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
